smg_segment_driver: RTL and testbench

Segment-data side of the six-digit seven-segment display on the AX309 board. It takes a binary value, converts it to six BCD digits with a sequential double-dabble engine, and commits the digits atomically to a display register. It then drives the active-low segment bus `seg_sig` for whichever digit the existing digit scanner is selecting on `scan_sig`. It sits between the application logic, which loads numbers, and the board pins, alongside the scanner.

---
 rtl/smg_segment_driver.sv | 169 ++++++++++++++++
 tb/tb_smg_segment_driver.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/smg_segment_driver.sv
`timescale 1ns/1ps
// smg_segment_driver
// Converts a 20-bit binary value to six BCD digits with a sequential
// double-dabble engine, commits the digit codes atomically to a display
// register, and drives the active-low segment bus for the digit currently
// selected by the external scanner.
module smg_segment_driver #(
  parameter bit LZB = 1'b1
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [5:0]  scan_sig,
  input  logic [19:0] number,
  input  logic        load,
  output logic        busy,
  output logic [7:0]  seg_sig
);

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [19:0] MAX_SHOWN = 20'd999999;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    COMMIT
  } state_t;

  state_t           state_q, state_d;
  logic [19:0]      bin_q, bin_d;
  logic [23:0]      bcd_q, bcd_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [5:0][7:0]  disp_q, disp_d;
  logic [7:0]       seg_q, seg_d;

  logic [23:0]      bcd_adj;
  logic [5:0][7:0]  commit_codes;

  // Digit value to active-low segment code (dp,g,f,e,d,c,b,a).
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd0:    c = 8'hC0;
      4'd1:    c = 8'hF9;
      4'd2:    c = 8'hA4;
      4'd3:    c = 8'hB0;
      4'd4:    c = 8'h99;
      4'd5:    c = 8'h92;
      4'd6:    c = 8'h82;
      4'd7:    c = 8'hF8;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h90;
      default: c = SEG_BLANK;
    endcase
    return c;
  endfunction

  // Add-3 correction on every BCD nibble that is 5 or more (no inter-nibble carry).
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 6; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Digit codes to be committed: dashes on overflow, else BCD with optional
  // leading-zero blanking (the rightmost digit is never blanked).
  always_comb begin
    logic       leading;
    logic [3:0] d;
    int unsigned pos;
    commit_codes = '1;
    leading      = 1'b1;
    d            = '0;
    pos          = 0;
    for (int unsigned j = 0; j < 6; j++) begin
      pos = 5 - j;
      d   = bcd_q[4*pos +: 4];
      if (ovf_q) begin
        commit_codes[pos] = SEG_DASH;
      end else if (LZB && leading && (d == 4'd0) && (pos != 0)) begin
        commit_codes[pos] = SEG_BLANK;
      end else begin
        commit_codes[pos] = seg_code(d);
        leading           = 1'b0;
      end
    end
  end

  // Next-state logic for the load / convert / commit sequence.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    disp_d  = disp_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          bin_d   = number;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = (number > MAX_SHOWN);
          state_d = CONV;
        end
      end
      CONV: begin
        busy  = 1'b1;
        // Shift {bcd, bin} left by one; the top BCD bit falls off.
        bcd_d = {bcd_adj[22:0], bin_q[19]};
        bin_d = {bin_q[18:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd19) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        busy    = 1'b1;
        disp_d  = commit_codes;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Segment mux: exactly one low select bit picks a digit, anything else blanks.
  always_comb begin
    case (scan_sig)
      6'b011111: seg_d = disp_q[5];
      6'b101111: seg_d = disp_q[4];
      6'b110111: seg_d = disp_q[3];
      6'b111011: seg_d = disp_q[2];
      6'b111101: seg_d = disp_q[1];
      6'b111110: seg_d = disp_q[0];
      default:   seg_d = SEG_BLANK;
    endcase
  end

  // State, datapath and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      disp_q  <= '1;
      seg_q   <= '1;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
      seg_q   <= seg_d;
    end
  end

  assign seg_sig = seg_q;

endmodule

// File: tb/tb_smg_segment_driver.sv
`timescale 1ns/1ps
// Directed bench for smg_segment_driver: two instances (blanking on/off)
// share stimulus; expected segment codes are hand-computed constants.
module tb_smg_segment_driver;

  logic        CLK;
  logic        RSTn;
  logic [5:0]  scan_sig;
  logic [19:0] number;
  logic        load;
  logic        busy, busy_nz;
  logic [7:0]  seg_sig, seg_nz;

  int checks = 0;
  int errors = 0;

  smg_segment_driver #(.LZB(1'b1)) dut (
    .CLK(CLK), .RSTn(RSTn), .scan_sig(scan_sig), .number(number),
    .load(load), .busy(busy), .seg_sig(seg_sig)
  );

  smg_segment_driver #(.LZB(1'b0)) dut_nz (
    .CLK(CLK), .RSTn(RSTn), .scan_sig(scan_sig), .number(number),
    .load(load), .busy(busy_nz), .seg_sig(seg_nz)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Issue a one-cycle load, then verify busy stays high for exactly 21 cycles.
  task automatic do_load(input logic [19:0] n);
    int cnt;
    number = n;
    load   = 1'b1;
    tick();
    load = 1'b0;
    check("busy_on", {31'd0, busy}, 32'd1);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!busy) break;
      cnt++;
    end
    check("busy_len", cnt, 32'd21);
  endtask

  // Select each digit left to right and compare the segment code one cycle later.
  task automatic sweep(input string tag, input logic [47:0] e, input bit nz);
    logic [5:0] one;
    int unsigned p;
    one = 6'b000001;
    for (int unsigned j = 0; j < 6; j++) begin
      p = 5 - j;
      scan_sig = ~(one << p);
      tick();
      if (nz) check($sformatf("%s_d%0d", tag, p), {24'd0, seg_nz}, {24'd0, e[8*p +: 8]});
      else    check($sformatf("%s_d%0d", tag, p), {24'd0, seg_sig}, {24'd0, e[8*p +: 8]});
    end
  endtask

  initial begin
    RSTn     = 1'b0;
    scan_sig = 6'b011111;
    number   = '0;
    load     = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_seg", {24'd0, seg_sig}, 32'hFF);
    check("rst_busy", {31'd0, busy}, 32'd0);
    RSTn = 1'b1;
    repeat (3) tick();
    check("post_rst_seg", {24'd0, seg_sig}, 32'hFF);

    // Basic load
    do_load(20'd123456);
    sweep("n123456", 48'hF9_A4_B0_99_92_82, 1'b0);

    // Leading-zero blanking on and off
    do_load(20'd305);
    sweep("n305_lzb", 48'hFF_FF_FF_B0_C0_92, 1'b0);
    sweep("n305_nolzb", 48'hC0_C0_C0_B0_C0_92, 1'b1);
    do_load(20'd0);
    sweep("n0_lzb", 48'hFF_FF_FF_FF_FF_C0, 1'b0);

    // Boundaries and invalid scan patterns
    do_load(20'd999999);
    sweep("n999999", 48'h90_90_90_90_90_90, 1'b0);
    scan_sig = 6'b111111;
    tick();
    check("scan_none", {24'd0, seg_sig}, 32'hFF);
    scan_sig = 6'b001111;
    tick();
    check("scan_multi", {24'd0, seg_sig}, 32'hFF);
    do_load(20'd1000000);
    sweep("n1000000", 48'hBF_BF_BF_BF_BF_BF, 1'b0);

    // Loads while busy are dropped; first accepted reload at k+22
    scan_sig = 6'b111101;
    number   = 20'd42;
    load     = 1'b1;
    tick();                         // edge k
    number = 20'd777777;
    for (int e = 1; e <= 22; e++) begin
      load = (e == 5 || e == 21 || e == 22);
      if (e == 22) number = 20'd8;
      tick();
      if (e == 5)  check("hs_busy_k5", {31'd0, busy}, 32'd1);
      if (e == 21) check("hs_drop_k21", {31'd0, busy}, 32'd0);
      if (e == 22) begin
        check("hs_accept_k22", {31'd0, busy}, 32'd1);
        check("hs_shows42", {24'd0, seg_sig}, 32'h99);
      end
    end
    load = 1'b0;
    begin
      int guard;
      guard = 0;
      while (busy && guard < 40) begin
        tick();
        guard++;
      end
      check("hs_done", {31'd0, busy}, 32'd0);
    end
    sweep("n8", 48'hFF_FF_FF_FF_FF_80, 1'b0);

    // Abort mid-conversion via reset
    number = 20'd654321;
    load   = 1'b1;
    tick();
    load = 1'b0;
    repeat (10) tick();
    RSTn = 1'b0;
    #2;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_seg", {24'd0, seg_sig}, 32'hFF);
    tick();
    RSTn = 1'b1;
    repeat (30) tick();
    sweep("abort_blank", 48'hFF_FF_FF_FF_FF_FF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
